mips_multicycle_ctrl: RTL
=========================

Name: mips_multicycle_ctrl

Overview:
Moore-style main control FSM for the multicycle MIPS datapath. It sequences one instruction over 3–5 states plus memory wait cycles, driving every datapath select and write enable. The outputs it drives include reg_dst to the RegDst mux and the select lines for the ALU-source, memory-address and PC-source muxes. A `mem_ready` handshake lets the shared instruction/data memory stall the sequence.

Parameters:
- OP_W, 6, opcode field width
- FN_W, 6, funct field width

Ports:
- clk  input  1  rising-edge clock, the only clock
- reset  input  1  synchronous, active-high
- opcode  input  6  instr[31:26] from the instruction register
- funct  input  6  instr[5:0] from the instruction register
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory completes the current access this cycle
- pc_en  output  1  PC load enable
- iord  output  1  memory address select: 0 = PC, 1 = ALUOut
- mem_write  output  1  memory write request (level)
- mem_read  output  1  memory read request (level)
- ir_write  output  1  instruction register load
- reg_dst  output  1  write register select: 1 = rd, 0 = rt
- mem_to_reg  output  1  write-back data: 1 = MDR, 0 = ALUOut
- reg_write  output  1  register file write enable
- alu_src_a  output  1  ALU A: 0 = PC, 1 = register A
- alu_src_b  output  2  ALU B: 00 = B, 01 = const 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- alu_ctrl  output  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- pc_src  output  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- illegal_op  output  1  one-cycle pulse in DECODE for an unsupported opcode
- state_o  output  4  current state, for debug

Behaviour:
- Clock and reset: single clock `clk`; reset `reset` is synchronous and active-high. The state register is the only storage.
- Reset:
  - The cycle `reset` is sampled high, state goes to FETCH on that edge.
  - While `reset` is high, all enables and requests are forced to 0: pc_en, mem_write, mem_read, ir_write, reg_write, illegal_op.
  - Mux selects are don't-care during reset but are driven with their FETCH values.
  - Reset mid-instruction abandons the instruction; no partial register or memory write follows.
- States and outputs (signals not listed are 0):
  - FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_ctrl=add, pc_src=00. ir_write and pc_en are asserted only when mem_ready=1. Stay in FETCH while mem_ready=0, else go to DECODE.
  - DECODE: alu_src_a=0, alu_src_b=11, alu_ctrl=add (branch target). Next state by opcode:
    - 100011 (lw) or 101011 (sw) → MEMADR
    - 000000 (R-type) → EXECUTE
    - 000100 (beq) → BRANCH
    - 001000 (addi) → ADDIEX
    - 000010 (j) → JUMP
    - any other opcode → FETCH, with illegal_op=1 for this cycle
  - MEMADR: alu_src_a=1, alu_src_b=10, alu_ctrl=add. lw → MEMRD; sw → MEMWR.
  - MEMRD: mem_read=1, iord=1. Hold while mem_ready=0, else → MEMWB.
  - MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1 → FETCH.
  - MEMWR: mem_write=1, iord=1. Hold while mem_ready=0, else → FETCH. The write commits only in the mem_ready=1 cycle.
  - EXECUTE: alu_src_a=1, alu_src_b=00, alu_ctrl=decode(funct) → ALUWB.
  - ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1 → FETCH.
  - BRANCH: alu_src_a=1, alu_src_b=00, alu_ctrl=sub, pc_src=01, pc_en=zero → FETCH.
  - ADDIEX: alu_src_a=1, alu_src_b=10, alu_ctrl=add → ADDIWB.
  - ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1 → FETCH.
  - JUMP: pc_src=10, pc_en=1 → FETCH.
- Funct decode (EXECUTE only):
  - 100000 → 010 (add)
  - 100010 → 110 (sub)
  - 100100 → 000 (and)
  - 100101 → 001 (or)
  - 101010 → 111 (slt)
  - any other funct → 010 (add); no illegal flag.
- Latency with mem_ready tied to 1:
  - beq, j: 3 cycles
  - R-type, sw, addi: 4 cycles
  - lw: 5 cycles
  - Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds one cycle.
- Output timing: all outputs are combinational from state (plus zero/mem_ready where stated). opcode and funct must be stable from DECODE until the instruction ends; IR only changes in FETCH, which guarantees this.
- At most one of reg_write, mem_write, pc_en(jump/branch) is asserted per cycle outside FETCH.

Decomposition:
- Package `mips_ctrl_pkg` holds:
  - state enum, 4-bit encoding: FETCH = 0 through JUMP = 11
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J
  - funct constants
  - ALU_ADD/SUB/AND/OR/SLT codes
  - alu_src_b and pc_src select codes
- One sub-module, `alu_decoder`: combinational (alu_op[1:0], funct) → alu_ctrl, reused in the single-cycle core.

Test Plan:
- Reset, then 1 cycle of reset=0 with mem_ready=1: state_o=FETCH, ir_write=1, pc_en=1, alu_src_b=01. Assert reset in MEMRD: next state FETCH, reg_write is never asserted.
- R-type add (opcode 000000, funct 100000), mem_ready=1: states FETCH→DECODE→EXECUTE→ALUWB. alu_ctrl=010 in EXECUTE; reg_dst=1 and reg_write=1 only in the 4th cycle.
- lw (100011) with mem_ready low for 2 cycles in MEMRD: 7 cycles total; MEMWB has reg_dst=0, mem_to_reg=1. sw (101011): mem_write held for 3 cycles, no reg_write.
- beq (000100) with zero=1: pc_en=1, pc_src=01 in cycle 3. With zero=0: pc_en=0 and the next state is FETCH.
- j (000010): pc_src=10, pc_en=1 in cycle 3. addi (001000): ADDIWB reg_dst=0, mem_to_reg=0, alu_src_b=10 in ADDIEX.
- Opcode 111111: illegal_op=1 for exactly one cycle in DECODE, back to FETCH, no write enable asserted. FETCH with mem_ready=0 for 3 cycles: ir_write and pc_en stay 0 until the ready cycle.

Source files
------------

// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states, opcode and
// funct fields, ALU control codes and datapath mux selects.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // ALU operation class handed to alu_decoder by the main FSM.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    function automatic logic [2:0] funct_to_alu(input logic [5:0] fn);
        case (fn)
            FN_ADD:  return ALU_ADD;
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_SLT:  return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Controller <-> datapath bundle: instruction fields and status in, selects and
// enables out. mem_read/mem_write are level requests; the access completes in
// the cycle mem_ready is high, and the requester holds the request until then.
interface mips_multicycle_ctrl_if #(
    parameter int OP_W = 6,
    parameter int FN_W = 6
);
    logic [OP_W-1:0] opcode;
    logic [FN_W-1:0] funct;
    logic            zero;
    logic            mem_ready;

    logic            pc_en;
    logic            iord;
    logic            mem_write;
    logic            mem_read;
    logic            ir_write;
    logic            reg_dst;
    logic            mem_to_reg;
    logic            reg_write;
    logic            alu_src_a;
    logic [1:0]      alu_src_b;
    logic [2:0]      alu_ctrl;
    logic [1:0]      pc_src;
    logic            illegal_op;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output pc_en, iord, mem_write, mem_read, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, alu_ctrl, pc_src, illegal_op
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  pc_en, iord, mem_write, mem_read, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, alu_ctrl, pc_src, illegal_op
    );
endinterface

// File: rtl/mips_multicycle_ctrl_alu_decoder.sv
// ALU control decoder: maps the FSM's operation class and the funct field to
// the 3-bit ALU control code. Shared with the single-cycle core.
module alu_decoder
    import mips_ctrl_pkg::*;
#(
    parameter int FN_W = 6
) (
    input  logic [1:0]      alu_op,
    input  logic [FN_W-1:0] funct,
    output logic [2:0]      alu_ctrl
);

    always_comb begin
        alu_ctrl = ALU_ADD;
        case (alu_op)
            ALUOP_ADD:   alu_ctrl = ALU_ADD;
            ALUOP_SUB:   alu_ctrl = ALU_SUB;
            ALUOP_FUNCT: alu_ctrl = funct_to_alu(funct);
            default:     alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Moore main control FSM for the multicycle MIPS datapath; one state register,
// all outputs decoded from the current state (plus zero/mem_ready where used).
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int OP_W = 6,
    parameter int FN_W = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    mips_multicycle_ctrl_if.master bus,
    output logic [3:0]             state_o
);

    state_t          state;
    state_t          state_next;
    logic [OP_W-1:0] opcode;
    logic [FN_W-1:0] funct;
    logic            zero;
    logic            mem_ready;

    logic            pc_en;
    logic            iord;
    logic            mem_write;
    logic            mem_read;
    logic            ir_write;
    logic            reg_dst;
    logic            mem_to_reg;
    logic            reg_write;
    logic            alu_src_a;
    logic [1:0]      alu_src_b;
    logic [1:0]      alu_op;
    logic            alu_active;
    logic [2:0]      dec_ctrl;
    logic [1:0]      pc_src;
    logic            illegal_op;

    assign opcode    = bus.opcode;
    assign funct     = bus.funct;
    assign zero      = bus.zero;
    assign mem_ready = bus.mem_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        pc_en      = 1'b0;
        iord       = 1'b0;
        mem_write  = 1'b0;
        mem_read   = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REG;
        alu_op     = ALUOP_ADD;
        alu_active = 1'b0;
        pc_src     = PCSRC_ALU;
        illegal_op = 1'b0;

        case (state)
            FETCH: begin
                mem_read   = 1'b1;
                alu_src_b  = SRCB_FOUR;
                alu_active = 1'b1;
                ir_write   = mem_ready;
                pc_en      = mem_ready;
                if (mem_ready) state_next = DECODE;
            end
            DECODE: begin
                // Speculatively compute the branch target into ALUOut.
                alu_src_b  = SRCB_IMM_SH2;
                alu_active = 1'b1;
                case (opcode)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_RTYPE:     state_next = EXECUTE;
                    OP_BEQ:       state_next = BRANCH;
                    OP_ADDI:      state_next = ADDIEX;
                    OP_J:         state_next = JUMP;
                    default: begin
                        state_next = FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_IMM;
                alu_active = 1'b1;
                state_next = (opcode == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready) state_next = MEMWB;
            end
            MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                state_next = FETCH;
            end
            MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready) state_next = FETCH;
            end
            EXECUTE: begin
                alu_src_a  = 1'b1;
                alu_op     = ALUOP_FUNCT;
                alu_active = 1'b1;
                state_next = ALUWB;
            end
            ALUWB: begin
                reg_dst    = 1'b1;
                reg_write  = 1'b1;
                state_next = FETCH;
            end
            BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = ALUOP_SUB;
                alu_active = 1'b1;
                pc_src     = PCSRC_ALUOUT;
                pc_en      = zero;
                state_next = FETCH;
            end
            ADDIEX: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_IMM;
                alu_active = 1'b1;
                state_next = ADDIWB;
            end
            ADDIWB: begin
                reg_write  = 1'b1;
                state_next = FETCH;
            end
            JUMP: begin
                pc_src     = PCSRC_JUMP;
                pc_en      = 1'b1;
                state_next = FETCH;
            end
            default: state_next = FETCH;
        endcase

        // Reset kills every enable and parks the selects on their FETCH values.
        if (reset) begin
            pc_en      = 1'b0;
            mem_write  = 1'b0;
            mem_read   = 1'b0;
            ir_write   = 1'b0;
            reg_write  = 1'b0;
            illegal_op = 1'b0;
            iord       = 1'b0;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
            alu_src_a  = 1'b0;
            alu_src_b  = SRCB_FOUR;
            alu_op     = ALUOP_ADD;
            alu_active = 1'b1;
            pc_src     = PCSRC_ALU;
        end
    end

    alu_decoder #(.FN_W(FN_W)) u_alu_decoder (
        .alu_op   (alu_op),
        .funct    (funct),
        .alu_ctrl (dec_ctrl)
    );

    assign bus.pc_en      = pc_en;
    assign bus.iord       = iord;
    assign bus.mem_write  = mem_write;
    assign bus.mem_read   = mem_read;
    assign bus.ir_write   = ir_write;
    assign bus.reg_dst    = reg_dst;
    assign bus.mem_to_reg = mem_to_reg;
    assign bus.reg_write  = reg_write;
    assign bus.alu_src_a  = alu_src_a;
    assign bus.alu_src_b  = alu_src_b;
    // States that do not use the ALU present a zero control code.
    assign bus.alu_ctrl   = alu_active ? dec_ctrl : 3'b000;
    assign bus.pc_src     = pc_src;
    assign bus.illegal_op = illegal_op;
    assign state_o        = state;

endmodule
